// File: rtl/sr_cmd_arbiter_pkg.sv
// Shared definitions for the SR cell command arbiter.
// Op encodings and FSM state type.
package sr_cmd_arbiter_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/sr_cmd_arbiter_rr_grant.sv
// Combinational round-robin picker: first valid at or above
// the pointer, wrapping modulo N.
module rr_grant #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_winner,
  output logic         o_found
);

  logic [W-1:0] cand;

  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'((int'(i_ptr) + i) % N);
      if (!o_found && i_valid[cand]) begin
        o_found  = 1'b1;
        o_winner = cand;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_arbiter.sv
// Round-robin command sequencer driving a bank of SR cells
// with single-cycle S/R pulses and a shadow of the cell state.
module sr_cmd_arbiter
  import sr_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic [NUM_REQ-1:0]       i_Req_Valid,
  input  logic [2*NUM_REQ-1:0]     i_Req_Op,
  input  logic [IDX_W*NUM_REQ-1:0] i_Req_Idx,
  output logic [NUM_REQ-1:0]       o_Req_Ack,
  output logic [NUM_BITS-1:0]      o_S,
  output logic [NUM_BITS-1:0]      o_R,
  output logic [NUM_BITS-1:0]      o_Shadow_Q,
  output logic                     o_Busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [1:0]         op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_BITS-1:0] shadow_q, shadow_d;

  logic [PTR_W-1:0]    gnt_id;
  logic                gnt_found;
  logic [1:0]          raw_op;
  logic [IDX_W-1:0]    raw_idx;
  logic [NUM_BITS-1:0] onehot;

  rr_grant #(
    .N (NUM_REQ),
    .W (PTR_W)
  ) u_grant (
    .i_valid  (i_Req_Valid),
    .i_ptr    (ptr_q),
    .o_winner (gnt_id),
    .o_found  (gnt_found)
  );

  assign raw_op  = i_Req_Op[2*int'(gnt_id) +: 2];
  assign raw_idx = i_Req_Idx[IDX_W*int'(gnt_id) +: IDX_W];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    unique case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (gnt_found) begin
          win_d = gnt_id;
          idx_d = raw_idx;
          op_d  = raw_op;
          // Toggle is fixed to a concrete set/clear at grant time
          if (raw_op == OP_TGL)
            op_d = shadow_q[raw_idx] ? OP_CLR : OP_SET;
          state_d = (raw_op == OP_NOP) ? ST_ACK : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        shadow_d[idx_q] = (op_q == OP_SET);
        state_d = ST_ACK;
      end
      ST_ACK: begin
        ptr_d = (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      win_q    <= '0;
      op_q     <= OP_NOP;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  assign onehot = NUM_BITS'(1) << idx_q;

  // INIT is also the reset state; the clear-all burst waits for release
  always_comb begin
    o_S = '0;
    o_R = '0;
    if (state_q == ST_INIT) begin
      o_R = i_Rst ? '0 : '1;
    end else if (state_q == ST_DRIVE) begin
      if (op_q == OP_SET) o_S = onehot;
      if (op_q == OP_CLR) o_R = onehot;
    end
  end

  assign o_Req_Ack  = (state_q == ST_ACK) ? (NUM_REQ'(1) << win_q) : '0;
  assign o_Shadow_Q = shadow_q;
  assign o_Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Directed bench for sr_cmd_arbiter: reset, set/toggle/nop,
// arbitration order, same-index serialization, mid-op reset.
module tb_sr_cmd_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  valid;
  logic [7:0]  op;
  logic [11:0] idx;
  logic [3:0]  ack;
  logic [7:0]  s;
  logic [7:0]  r;
  logic [7:0]  shadow;
  logic        busy;

  int checks;
  int failures;

  sr_cmd_arbiter #(
    .NUM_REQ  (4),
    .NUM_BITS (8),
    .IDX_W    (3)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Req_Valid (valid),
    .i_Req_Op    (op),
    .i_Req_Idx   (idx),
    .o_Req_Ack   (ack),
    .o_S         (s),
    .o_R         (r),
    .o_Shadow_Q  (shadow),
    .o_Busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [1:0] o,
                         input logic [2:0] x);
    valid[k]      = 1'b1;
    op[2*k +: 2]  = o;
    idx[3*k +: 3] = x;
  endtask

  task automatic apply_reset();
    valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = '0;
    op = '0;
    idx = '0;
    tick();
    tick();
    checks++;
    if (s !== 8'h00 || r !== 8'h00 || ack !== 4'h0) begin
      failures++;
      $display("FAIL rst_outs s=%h r=%h ack=%b exp 0", s, r, ack);
    end
    checks++;
    if (shadow !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_state shadow=%h busy=%b exp 00/1",
               shadow, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (r !== 8'hFF || s !== 8'h00) begin
      failures++;
      $display("FAIL init_pulse r=%h s=%h exp FF/00", r, s);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || shadow !== 8'h00 || ack !== 4'h0 ||
        r !== 8'h00) begin
      failures++;
      $display("FAIL idle_after_init busy=%b sh=%h ack=%b r=%h",
               busy, shadow, ack, r);
    end
  endtask

  task automatic test_set();
    set_req(0, 2'b10, 3'd5);
    tick();
    checks++;
    if (s !== 8'h20 || r !== 8'h00 || ack !== 4'h0) begin
      failures++;
      $display("FAIL set_drive s=%h r=%h ack=%b exp 20/00/0000",
               s, r, ack);
    end
    tick();
    checks++;
    if (ack !== 4'b0001 || shadow !== 8'h20 || s !== 8'h00) begin
      failures++;
      $display("FAIL set_ack ack=%b sh=%h s=%h exp 0001/20/00",
               ack, shadow, s);
    end
    valid = '0;
    tick();
  endtask

  task automatic test_toggle();
    set_req(2, 2'b11, 3'd5);
    tick();
    checks++;
    if (r !== 8'h20 || s !== 8'h00) begin
      failures++;
      $display("FAIL tgl1_drive r=%h s=%h exp 20/00", r, s);
    end
    tick();
    checks++;
    if (ack !== 4'b0100 || shadow !== 8'h00) begin
      failures++;
      $display("FAIL tgl1_ack ack=%b sh=%h exp 0100/00", ack, shadow);
    end
    valid = '0;
    tick();
    set_req(2, 2'b11, 3'd5);
    tick();
    checks++;
    if (s !== 8'h20 || r !== 8'h00) begin
      failures++;
      $display("FAIL tgl2_drive s=%h r=%h exp 20/00", s, r);
    end
    tick();
    checks++;
    if (ack !== 4'b0100 || shadow !== 8'h20) begin
      failures++;
      $display("FAIL tgl2_ack ack=%b sh=%h exp 0100/20", ack, shadow);
    end
    valid = '0;
    tick();
  endtask

  task automatic test_all_requesters();
    logic [7:0] exp_pulse;
    logic [3:0] exp_ack;
    apply_reset();
    for (int k = 0; k < 4; k++) set_req(k, 2'b10, 3'(k));
    for (int g = 0; g < 4; g++) begin
      exp_pulse = 8'h01 << g;
      exp_ack   = 4'h1 << g;
      tick();
      checks++;
      if (s !== exp_pulse || r !== 8'h00) begin
        failures++;
        $display("FAIL all_drive g=%0d s=%h r=%h exp %h/00",
                 g, s, r, exp_pulse);
      end
      tick();
      checks++;
      if (ack !== exp_ack || (s | r) !== 8'h00) begin
        failures++;
        $display("FAIL all_ack g=%0d ack=%b s|r=%h exp %b/00",
                 g, ack, s | r, exp_ack);
      end
      if (g == 3) valid = '0;
      tick();
      checks++;
      if (busy !== 1'b0 || ack !== 4'h0 || (s & r) !== 8'h00) begin
        failures++;
        $display("FAIL all_idle g=%0d busy=%b ack=%b s&r=%h",
                 g, busy, ack, s & r);
      end
    end
    checks++;
    if (shadow !== 8'h0F) begin
      failures++;
      $display("FAIL all_shadow got=%h exp 0F", shadow);
    end
  endtask

  task automatic test_same_idx();
    apply_reset();
    set_req(1, 2'b11, 3'd4);
    set_req(2, 2'b11, 3'd4);
    tick();
    checks++;
    if (s !== 8'h10 || r !== 8'h00) begin
      failures++;
      $display("FAIL same1_drive s=%h r=%h exp 10/00", s, r);
    end
    tick();
    checks++;
    if (ack !== 4'b0010 || shadow !== 8'h10) begin
      failures++;
      $display("FAIL same1_ack ack=%b sh=%h exp 0010/10", ack, shadow);
    end
    valid[1] = 1'b0;
    tick();
    tick();
    checks++;
    if (r !== 8'h10 || s !== 8'h00) begin
      failures++;
      $display("FAIL same2_drive r=%h s=%h exp 10/00", r, s);
    end
    tick();
    checks++;
    if (ack !== 4'b0100 || shadow !== 8'h00) begin
      failures++;
      $display("FAIL same2_ack ack=%b sh=%h exp 0100/00", ack, shadow);
    end
    valid = '0;
    tick();
  endtask

  task automatic test_nop();
    set_req(1, 2'b00, 3'd6);
    tick();
    checks++;
    if (ack !== 4'b0010 || s !== 8'h00 || r !== 8'h00 ||
        shadow !== 8'h00) begin
      failures++;
      $display("FAIL nop_ack ack=%b s=%h r=%h sh=%h exp 0010/00/00/00",
               ack, s, r, shadow);
    end
    valid = '0;
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== 4'h0) begin
      failures++;
      $display("FAIL nop_idle busy=%b ack=%b exp 0/0000", busy, ack);
    end
  endtask

  task automatic test_drop_valid();
    set_req(3, 2'b10, 3'd7);
    tick();
    checks++;
    if (s !== 8'h80) begin
      failures++;
      $display("FAIL drop_drive s=%h exp 80", s);
    end
    valid = '0;
    op = '0;
    tick();
    checks++;
    if (ack !== 4'b1000 || shadow !== 8'h80) begin
      failures++;
      $display("FAIL drop_ack ack=%b sh=%h exp 1000/80", ack, shadow);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(0, 2'b10, 3'd6);
    tick();
    checks++;
    if (s !== 8'h40) begin
      failures++;
      $display("FAIL mid_drive s=%h exp 40", s);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (s !== 8'h00 || r !== 8'h00 || ack !== 4'h0 ||
        shadow !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_abort s=%h r=%h ack=%b sh=%h busy=%b",
               s, r, ack, shadow, busy);
    end
    valid = '0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (r !== 8'hFF || s !== 8'h00) begin
      failures++;
      $display("FAIL mid_init r=%h s=%h exp FF/00", r, s);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ack !== 4'h0 || shadow !== 8'h00 || (s | r) !== 8'h00) begin
        failures++;
        $display("FAIL mid_after c=%0d ack=%b sh=%h s|r=%h",
                 c, ack, shadow, s | r);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    valid = '0;
    op = '0;
    idx = '0;
    test_reset();
    test_set();
    test_toggle();
    test_all_requesters();
    test_same_idx();
    test_nop();
    test_drop_valid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
